// File: rtl/mips32_hazard_ctrl_pkg.sv
// Shared definitions for the pipe_mips32 interlock controller.
//  - opcode constants (ADD..HLT, BEQZ, BNEQZ) and instruction field positions
//  - FSM state encoding (RUN, DRAIN, HALT)
//  - scoreboard entry and decoded-instruction structs
//  - forwarding-select encodings plus small helper functions
package mips32_hazard_ctrl_pkg;

  // Instruction field positions
  localparam int OP_MSB = 31, OP_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;

  // Opcodes
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Cycles spent in DRAIN after HLT leaves ID (EX, MEM, WB empty out)
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  // Forwarding mux selects for the operand entering EX next cycle
  localparam logic [1:0] FWD_REG    = 2'b00;  // register file
  localparam logic [1:0] FWD_EXMEM  = 2'b01;  // EX/MEM ALUOut
  localparam logic [1:0] FWD_MEMWB  = 2'b10;  // MEM/WB LMD/ALUOut

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  // Read/write enables already exclude R0, so R0 never takes part in a hazard.
  typedef struct packed {
    logic       rd_a_en;
    logic [4:0] rd_a;
    logic       rd_b_en;
    logic [4:0] rd_b;
    logic       wr_en;
    logic [4:0] wr_dst;
    logic       is_load;
    logic       is_hlt;
  } decode_t;

  function automatic logic slot_hit(sb_entry_t e, logic en, logic [4:0] r);
    return en & e.valid & (e.dest == r);
  endfunction

  // The youngest writer (EX slot) takes precedence over the MEM slot.
  function automatic logic [1:0] fwd_select(sb_entry_t ex, sb_entry_t mem,
                                            logic en, logic [4:0] r);
    if (slot_hit(ex, en, r))       return FWD_EXMEM;
    else if (slot_hit(mem, en, r)) return FWD_MEMWB;
    else                           return FWD_REG;
  endfunction

endpackage

// File: rtl/mips32_hazard_ctrl_ir_decode.sv
// mips32_ir_decode: purely combinational register-usage decode of the
// instruction held in IF/ID.
//  ir  in  32  instruction word
//  dec out     {rd_a_en, rd_a, rd_b_en, rd_b, wr_en, wr_dst, is_load, is_hlt}
module mips32_ir_decode
  import mips32_hazard_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output decode_t     dec
);

  logic [5:0] op;
  logic [4:0] rs, rt, rd;

  assign op = ir[OP_MSB:OP_LSB];
  assign rs = ir[RS_MSB:RS_LSB];
  assign rt = ir[RT_MSB:RT_LSB];
  assign rd = ir[RD_MSB:RD_LSB];

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    dec      = '0;
    dec.rd_a = rs;
    dec.rd_b = rt;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        dec.rd_a_en = 1'b1;
        dec.rd_b_en = 1'b1;
        dec.wr_en   = 1'b1;
        dec.wr_dst  = rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        dec.rd_a_en = 1'b1;
        dec.wr_en   = 1'b1;
        dec.wr_dst  = rt;
      end
      OP_LW: begin
        dec.rd_a_en = 1'b1;
        dec.wr_en   = 1'b1;
        dec.wr_dst  = rt;
        dec.is_load = 1'b1;
      end
      OP_SW: begin
        dec.rd_a_en = 1'b1;
        dec.rd_b_en = 1'b1;
      end
      OP_BEQZ, OP_BNEQZ: dec.rd_a_en = 1'b1;
      OP_HLT:            dec.is_hlt  = 1'b1;
      default: ;
    endcase
    // R0 is hard-wired zero: never a real source or destination.
    if (rs == 5'd0)         dec.rd_a_en = 1'b0;
    if (rt == 5'd0)         dec.rd_b_en = 1'b0;
    if (dec.wr_dst == 5'd0) dec.wr_en   = 1'b0;
  end

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// mips32_hazard_ctrl: interlock/sequencing controller for the 5-stage
// pipe_mips32 datapath. Tracks in-flight writers in a 3-slot scoreboard
// (EX, MEM, WB), stalls IF/ID on RAW hazards, flushes on taken branches,
// drains the pipe after HLT and then freezes it.
// Optional feature macro: MIPS32_FORWARD_EN (only load-use is a hazard;
// adds fwd_a_sel/fwd_b_sel outputs).
//  clk1            in   pipeline clock
//  rst_n           in   synchronous active-low reset
//  id_ir/id_valid  in   instruction in IF/ID and its valid flag
//  ex_branch_taken in   branch in EX resolved taken
//  pc_en, ifid_en  out  PC / IF/ID load enables
//  idex_bubble     out  load NOP into ID/EX
//  flush_ifid      out  squash IF/ID
//  halted          out  pipeline drained after HLT
//  stall_cnt       out  saturating stall-cycle counter
//  fwd_a_sel/_b    out  (MIPS32_FORWARD_EN only) operand forwarding selects
module mips32_hazard_ctrl
  import mips32_hazard_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic [31:0]      id_ir,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             halted,
`ifdef MIPS32_FORWARD_EN
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
`endif
  output logic [CNT_W-1:0] stall_cnt
);

  decode_t          dec;
  sb_entry_t        sb_q [SB_DEPTH];
  state_t           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hazard, stall, issue;

  mips32_ir_decode u_decode (
    .ir  (id_ir),
    .dec (dec)
  );

`ifdef MIPS32_FORWARD_EN
  // ALU results are forwarded; only a load still in EX cannot supply its data in time.
  assign hazard = id_valid & sb_q[0].is_load &
                  (slot_hit(sb_q[0], dec.rd_a_en, dec.rd_a) |
                   slot_hit(sb_q[0], dec.rd_b_en, dec.rd_b));
  assign fwd_a_sel = fwd_select(sb_q[0], sb_q[1], dec.rd_a_en, dec.rd_a);
  assign fwd_b_sel = fwd_select(sb_q[0], sb_q[1], dec.rd_b_en, dec.rd_b);
`else
  // Without forwarding, any writer still in EX or MEM blocks the reader.
  // The WB slot is never checked: the register file writes before it is read.
  assign hazard = id_valid &
                  (slot_hit(sb_q[0], dec.rd_a_en, dec.rd_a) |
                   slot_hit(sb_q[0], dec.rd_b_en, dec.rd_b) |
                   slot_hit(sb_q[1], dec.rd_a_en, dec.rd_a) |
                   slot_hit(sb_q[1], dec.rd_b_en, dec.rd_b));
`endif

  // Priority: reset > HALT/DRAIN > flush > stall.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    halted      = 1'b0;
    stall       = 1'b0;
    issue       = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    if (rst_n) begin
      case (state_q)
        ST_HALT: begin
          halted      = 1'b1;
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        ST_DRAIN: begin
          // Hazards and branches are irrelevant while the last instructions retire.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (drain_q == 2'd0) state_d = ST_HALT;
          else                 drain_d = drain_q - 2'd1;
        end
        default: begin
          if (ex_branch_taken) begin
            // Squashed ID instruction neither issues nor counts as a stall.
            flush_ifid  = 1'b1;
            idex_bubble = 1'b1;
          end else if (hazard) begin
            stall       = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            issue = id_valid;
            if (id_valid && dec.is_hlt) begin
              pc_en   = 1'b0;
              state_d = ST_DRAIN;
              drain_d = DRAIN_CYCLES;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      // NOTE: scoreboard entries are reset so no stale writer survives into the next run.
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every slot shifts from its pre-edge value.
      sb_q[0] <= issue ? '{valid: dec.wr_en, dest: dec.wr_dst, is_load: dec.is_load}
                       : '0;
      for (int i = 1; i < SB_DEPTH; i++) sb_q[i] <= sb_q[i-1];
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
